timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//  8-bit up/down count stage of the APB timer. Consumes the divided clock clk_in from the clock divider.
//  clk_in is sampled in the PCLK domain and edge-detected, so there is a single clock and no derived-clock flops.
//  Holds TCNT and the sticky overflow/underflow flags (TSR) read back by the APB register block.
//  Writes from the register block arrive here as TCR/TDR levels plus write-1-to-clear strobes.
// PARAMETERS
//  CNT_W    8     counter/TDR width; wrap values derive from it (max = 2**CNT_W-1)
// PORTS
//  PCLK       in   1      system clock; the only clock
//  PRESETn    in   1      asynchronous, active-low reset
//  clk_in     in   1      divided clock from clock divider, synchronous to PCLK
//  TCR        in   8      control: [7] load, [5] dir (0 up, 1 down), [4] en, [1:0] cks (unused here)
//  TDR        in   CNT_W  reload value
//  tsr_clr    in   2      write-1-to-clear strobes: [0] ovf, [1] udf (one PCLK wide)
//  TCNT       out  CNT_W  current count
//  TSR        out  2      sticky flags: [0] ovf, [1] udf
//  ovf_pulse  out  1      1-cycle pulse on overflow wrap
//  udf_pulse  out  1      1-cycle pulse on underflow wrap
// BEHAVIOUR
//  Reset (async, PRESETn=0):
//   - TCNT=0, TSR=2'b00, ovf_pulse=udf_pulse=0.
//   - clk_d=1, so a high clk_in at reset release does not produce a tick.
//  Tick detect:
//   - clk_d <= clk_in each PCLK; tick = clk_in & ~clk_d.
//   - TCNT updates on the PCLK edge after clk_in is seen high: one PCLK of latency.
//  Priority each PCLK:
//   - load: if TCR[7]=1, TCNT <= TDR every cycle. Ticks are discarded and no flag or pulse is raised.
//   - count: else if TCR[4]=1 and tick, up: TCNT <= TCNT+1; down: TCNT <= TCNT-1.
//   - hold: else TCNT holds. Ticks seen with en=0 are dropped, not queued.
//  Wrap:
//   - up from all-ones -> 0: ovf_pulse=1 and TSR[0] set, same edge as the TCNT update.
//   - down from 0 -> all-ones: udf_pulse=1 and TSR[1] set, same edge.
//  Arithmetic: modulo 2**CNT_W. No saturation; no carry kept beyond the flag.
//  Flags:
//   - TSR bits are sticky until tsr_clr of the same bit.
//   - Set and clear in the same cycle: set wins.
//   - Clearing one bit never touches the other.
//  Live changes:
//   - A dir change mid-run applies at the next tick.
//   - Load deassert: counting resumes from TDR at the next tick.
//   - en 0->1: no spurious tick, because clk_d tracks clk_in continuously.
//  Pulses are 0 in every cycle without a wrap.
//  PRESETn low mid-count forces reset values immediately, regardless of PCLK.
// STRUCTURE
//  - timer_pkg: TCR bit indices (TCR_LOAD=7, TCR_DIR=5, TCR_EN=4, TCR_CKS_LSB=0) and TSR_OVF=0, TSR_UDF=1.
//  - Sub-module tick_edge_detect: clk_in sampler plus rising-edge pulse, reset value 1. Reusable by other divided-clock consumers.
//  - Remainder (counter, wrap detect, flags): one always block in this module.
// TESTING
//  1 Reset: PRESETn=0 with clk_in=1, then release -> TCNT=0x00, TSR=0; no count on the first PCLK.
//  2 Up overflow: TDR=0xFD, TCR=0x80 for 1 cycle, then TCR=0x10. After 3 clk_in rises -> TCNT=0x00, TSR=01, ovf_pulse high exactly 1 PCLK.
//  3 Down underflow: TDR=0x01 loaded, TCR=0x30. After 2 rises -> TCNT=0xFF, TSR=10, udf_pulse 1 PCLK.
//  4 Hold: TCNT=0x42, TCR=0x00, 5 clk_in rises -> TCNT stays 0x42; re-enable -> next rise gives 0x43.
//  5 Flag race: tsr_clr=01 on the same cycle as an overflow wrap -> TSR[0] stays 1. tsr_clr=10 alone -> only TSR[1] cleared.
//  6 Reset mid-run: TCNT=0x80 counting, PRESETn pulsed low between PCLK edges -> TCNT=0, TSR=0 immediately; counting restarts from 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared field positions for the timer's control and status registers.
package timer_pkg;

  localparam int TCR_LOAD    = 7;
  localparam int TCR_DIR     = 5;
  localparam int TCR_EN      = 4;
  localparam int TCR_CKS_LSB = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

endpackage

// File: rtl/tick_edge_detect.sv
// Samples a divided clock in the system clock domain and emits a one-cycle tick on its rising edge.
module tick_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic tick_o
);

  logic sig_d_q;

  // Resetting high means a signal already high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_d_q <= 1'b1;
    end else begin
      sig_d_q <= sig_i;
    end
  end

  assign tick_o = sig_i & ~sig_d_q;

endmodule

// File: rtl/timer_counter.sv
// Up/down count stage of the APB timer with sticky wrap flags and wrap pulses.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             clk_in,
  input  logic [7:0]       TCR,
  input  logic [CNT_W-1:0] TDR,
  input  logic [1:0]       tsr_clr,
  output logic [CNT_W-1:0] TCNT,
  output logic [1:0]       TSR,
  output logic             ovf_pulse,
  output logic             udf_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = '0;

  logic             tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tsr_q, tsr_d;
  logic             ovf_q, udf_q;
  logic             count_en, wrap_up, wrap_dn;
  logic             unused_tcr;

  assign unused_tcr = ^{TCR[6], TCR[3:TCR_CKS_LSB]};

  tick_edge_detect u_tick (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .sig_i  (clk_in),
    .tick_o (tick)
  );

  assign count_en = ~TCR[TCR_LOAD] & TCR[TCR_EN] & tick;
  assign wrap_up  = count_en & ~TCR[TCR_DIR] & (cnt_q == CNT_MAX);
  assign wrap_dn  = count_en &  TCR[TCR_DIR] & (cnt_q == CNT_MIN);

  assign cnt_d = TCR[TCR_LOAD] ? TDR :
                 !count_en     ? cnt_q :
                 TCR[TCR_DIR]  ? cnt_q - 1'b1 : cnt_q + 1'b1;

  // A flag being set in the same cycle as its clear strobe stays set.
  assign tsr_d[TSR_OVF] = wrap_up | (tsr_q[TSR_OVF] & ~tsr_clr[TSR_OVF]);
  assign tsr_d[TSR_UDF] = wrap_dn | (tsr_q[TSR_UDF] & ~tsr_clr[TSR_UDF]);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
      tsr_q <= 2'b00;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tsr_q <= tsr_d;
      ovf_q <= wrap_up;
      udf_q <= wrap_dn;
    end
  end

  assign TCNT      = cnt_q;
  assign TSR       = tsr_q;
  assign ovf_pulse = ovf_q;
  assign udf_pulse = udf_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed-vector bench for timer_counter: reset, wraps, hold, flag races and async reset.
module tb_timer_counter;

  logic       PCLK;
  logic       PRESETn;
  logic       clk_in;
  logic [7:0] TCR;
  logic [7:0] TDR;
  logic [1:0] tsr_clr;
  logic [7:0] TCNT;
  logic [1:0] TSR;
  logic       ovf_pulse;
  logic       udf_pulse;

  int vecCount = 0;
  int errCount = 0;

  timer_counter #(.CNT_W(8)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .clk_in    (clk_in),
    .TCR       (TCR),
    .TDR       (TDR),
    .tsr_clr   (tsr_clr),
    .TCNT      (TCNT),
    .TSR       (TSR),
    .ovf_pulse (ovf_pulse),
    .udf_pulse (udf_pulse)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one PCLK; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic rise();
    clk_in = 1'b1;
    cyc();
    clk_in = 1'b0;
    cyc();
  endtask

  task automatic loadValue(input logic [7:0] value);
    TDR = value;
    TCR = 8'h80;
    cyc();
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    clk_in  = 1'b1;
    TCR     = 8'h10;
    TDR     = 8'h00;
    tsr_clr = 2'b00;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    cyc();
    check("reset_tcnt", TCNT, 8'h00);
    check("reset_tsr", {6'd0, TSR}, 8'h00);
    check("reset_pulses", {6'd0, ovf_pulse, udf_pulse}, 8'h00);
    clk_in = 1'b0;
    TCR    = 8'h00;
    cyc();
  endtask

  task automatic test_up_overflow();
    loadValue(8'hFD);
    check("up_load", TCNT, 8'hFD);
    TCR = 8'h10;
    rise();
    rise();
    check("up_pre_wrap", TCNT, 8'hFF);
    check("up_no_early_pulse", {7'd0, ovf_pulse}, 8'h00);
    clk_in = 1'b1;
    cyc();
    check("up_wrap_tcnt", TCNT, 8'h00);
    check("up_wrap_pulse", {7'd0, ovf_pulse}, 8'h01);
    check("up_wrap_tsr", {6'd0, TSR}, 8'h01);
    clk_in = 1'b0;
    cyc();
    check("up_pulse_one_cycle", {7'd0, ovf_pulse}, 8'h00);
    check("up_tsr_sticky", {6'd0, TSR}, 8'h01);
    tsr_clr = 2'b01;
    cyc();
    tsr_clr = 2'b00;
    check("up_tsr_cleared", {6'd0, TSR}, 8'h00);
  endtask

  task automatic test_down_underflow();
    loadValue(8'h01);
    TCR = 8'h30;
    rise();
    check("dn_first", TCNT, 8'h00);
    clk_in = 1'b1;
    cyc();
    check("dn_wrap_tcnt", TCNT, 8'hFF);
    check("dn_wrap_pulse", {7'd0, udf_pulse}, 8'h01);
    check("dn_wrap_tsr", {6'd0, TSR}, 8'h02);
    clk_in = 1'b0;
    cyc();
    check("dn_pulse_one_cycle", {7'd0, udf_pulse}, 8'h00);
    tsr_clr = 2'b10;
    cyc();
    tsr_clr = 2'b00;
    check("dn_tsr_cleared", {6'd0, TSR}, 8'h00);
  endtask

  task automatic test_hold();
    loadValue(8'h42);
    TCR = 8'h00;
    for (int i = 0; i < 5; i++) rise();
    check("hold_tcnt", TCNT, 8'h42);
    TCR = 8'h10;
    cyc();
    check("hold_no_spurious", TCNT, 8'h42);
    rise();
    check("hold_resume", TCNT, 8'h43);
  endtask

  task automatic test_flag_race();
    loadValue(8'h00);
    TCR = 8'h30;
    rise();
    check("race_udf_set", {6'd0, TSR}, 8'h02);
    TCR     = 8'h10;
    clk_in  = 1'b1;
    tsr_clr = 2'b01;
    cyc();
    check("race_dir_change", TCNT, 8'h00);
    check("race_set_wins", {6'd0, TSR}, 8'h03);
    clk_in  = 1'b0;
    tsr_clr = 2'b10;
    cyc();
    tsr_clr = 2'b00;
    check("race_clear_udf_only", {6'd0, TSR}, 8'h01);
  endtask

  task automatic test_reset_mid_run();
    loadValue(8'h7F);
    TCR = 8'h10;
    rise();
    check("midrst_pre", TCNT, 8'h80);
    #2;
    PRESETn = 1'b0;
    #1;
    check("midrst_tcnt", TCNT, 8'h00);
    check("midrst_tsr", {6'd0, TSR}, 8'h00);
    #1;
    PRESETn = 1'b1;
    cyc();
    rise();
    check("midrst_restart", TCNT, 8'h01);
  endtask

  initial begin
    test_reset();
    test_up_overflow();
    test_down_underflow();
    test_hold();
    test_flag_race();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
